// File: rtl/autobaud_detector.sv
// Autobaud detector: times five falling edges of a 0x55 sync byte on rx and
// derives a baud-rate-generator divider from the measured interval.
module autobaud_detector #(
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned BRG_W   = 16,
    parameter int unsigned OS_LOG2 = 4
) (
    input  logic             clk,
    input  logic             cnt_rst,
    input  logic             abaud_start,
    input  logic             abort,
    input  logic             rx,
    input  logic             irq_clr,
    output logic [BRG_W-1:0] brg_out,
    output logic             brg_load,
    output logic             rxif,
    output logic             ovf,
    output logic             busy
);

    // N needs one extra bit: a 5th edge on the terminal count gives 2^CNT_W.
    localparam int unsigned N_W   = CNT_W + 1;
    localparam int unsigned SHIFT = 3 + OS_LOG2;
    localparam int unsigned EDG_W = 3;

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [EDG_W-1:0] EDGE_LAST = EDG_W'(4);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_START = 2'd1,
        MEASURE    = 2'd2,
        CALC       = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic             rx_meta;
    logic             rx_sync;
    logic             rx_prev;
    logic             fall_c;

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [EDG_W-1:0] edge_cnt;
    logic [EDG_W-1:0] edge_nxt;
    logic [N_W-1:0]   n_val;
    logic [N_W-1:0]   n_nxt;

    logic [N_W-1:0]   q_c;
    logic [N_W-1:0]   div_c;
    logic [BRG_W-1:0] brg_nxt;
    logic             load_nxt;
    logic             rxif_nxt;
    logic             ovf_nxt;

    // Two-flop synchronizer plus previous-sample register; idle-high reset
    // values keep a false edge from appearing after reset.
    always_ff @(posedge clk or posedge cnt_rst) begin
        if (cnt_rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    assign fall_c = rx_prev & ~rx_sync;

    // Divider from the captured interval: (N >> (3+OS_LOG2)) - 1, floored at 0.
    assign q_c   = n_val >> SHIFT;
    assign div_c = (q_c != '0) ? (q_c - N_W'(1)) : '0;

    // State register.
    always_ff @(posedge clk or posedge cnt_rst) begin
        if (cnt_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state, counter and result logic; abort overrides everything else.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        edge_nxt  = edge_cnt;
        n_nxt     = n_val;
        brg_nxt   = brg_out;
        load_nxt  = 1'b0;
        rxif_nxt  = rxif & ~irq_clr;
        ovf_nxt   = ovf & ~irq_clr;

        case (state)
            IDLE: begin
                if (abaud_start) begin
                    state_nxt = WAIT_START;
                end
            end
            WAIT_START: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (fall_c) begin
                    cnt_nxt   = '0;
                    edge_nxt  = EDG_W'(1);
                    state_nxt = MEASURE;
                end
            end
            MEASURE: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                    if (fall_c) begin
                        edge_nxt = edge_cnt + EDG_W'(1);
                    end
                    if (fall_c && (edge_cnt == EDGE_LAST)) begin
                        n_nxt     = {1'b0, cnt} + N_W'(1);
                        state_nxt = CALC;
                    end else if (cnt == CNT_MAX) begin
                        ovf_nxt   = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            CALC: begin
                state_nxt = IDLE;
                if (!abort) begin
                    brg_nxt  = div_c[BRG_W-1:0];
                    load_nxt = 1'b1;
                    rxif_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Measurement registers.
    always_ff @(posedge clk or posedge cnt_rst) begin
        if (cnt_rst) begin
            cnt      <= '0;
            edge_cnt <= '0;
            n_val    <= '0;
        end else begin
            cnt      <= cnt_nxt;
            edge_cnt <= edge_nxt;
            n_val    <= n_nxt;
        end
    end

    // Registered outputs; brg_out and brg_load change on the same edge.
    always_ff @(posedge clk or posedge cnt_rst) begin
        if (cnt_rst) begin
            brg_out  <= '0;
            brg_load <= 1'b0;
            rxif     <= 1'b0;
            ovf      <= 1'b0;
            busy     <= 1'b0;
        end else begin
            brg_out  <= brg_nxt;
            brg_load <= load_nxt;
            rxif     <= rxif_nxt;
            ovf      <= ovf_nxt;
            busy     <= (state_nxt != IDLE);
        end
    end

endmodule

// File: tb/tb_autobaud_detector.sv
// Scoreboard bench: three autobaud_detector configurations share one rx line;
// expected divider / overflow outcomes come from plain arithmetic on N = 8*P.
module tb_autobaud_detector;

    logic clk = 1'b0;
    logic cnt_rst;
    logic abaud_start;
    logic abort;
    logic rx;
    logic irq_clr;

    logic [15:0] brg_a;
    logic [7:0]  brg_b;
    logic [15:0] brg_c;
    logic        ld   [3];
    logic        rxif [3];
    logic        ovf  [3];
    logic        busy [3];

    int checks   = 0;
    int failures = 0;

    int q0[$];
    int q1[$];
    int q2[$];
    int last_brg [3];
    bit ovf_prev [3];
    int mon_e;
    bit mon_got;

    always #5 clk = ~clk;

    // dut 0: defaults, dut 1: 8-bit counter, dut 2: x4 oversampling
    autobaud_detector #(.CNT_W(16), .BRG_W(16), .OS_LOG2(4)) dut_a (
        .clk(clk), .cnt_rst(cnt_rst), .abaud_start(abaud_start), .abort(abort),
        .rx(rx), .irq_clr(irq_clr), .brg_out(brg_a), .brg_load(ld[0]),
        .rxif(rxif[0]), .ovf(ovf[0]), .busy(busy[0]));

    autobaud_detector #(.CNT_W(8), .BRG_W(8), .OS_LOG2(4)) dut_b (
        .clk(clk), .cnt_rst(cnt_rst), .abaud_start(abaud_start), .abort(abort),
        .rx(rx), .irq_clr(irq_clr), .brg_out(brg_b), .brg_load(ld[1]),
        .rxif(rxif[1]), .ovf(ovf[1]), .busy(busy[1]));

    autobaud_detector #(.CNT_W(16), .BRG_W(16), .OS_LOG2(2)) dut_c (
        .clk(clk), .cnt_rst(cnt_rst), .abaud_start(abaud_start), .abort(abort),
        .rx(rx), .irq_clr(irq_clr), .brg_out(brg_c), .brg_load(ld[2]),
        .rxif(rxif[2]), .ovf(ovf[2]), .busy(busy[2]));

    function automatic int brg_of(input int d);
        case (d)
            0:       return int'(brg_a);
            1:       return int'(brg_b);
            default: return int'(brg_c);
        endcase
    endfunction

    function automatic void check(input string name, input int d, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s dut%0d actual=%0d required=%0d time=%0t", name, d, act, exp, $time);
        end
    endfunction

    // Reference: N = 8 bit periods; overflow if the count passes 2^CNT_W.
    function automatic int model_result(input int d, input int p);
        int     cnt_w;
        int     os;
        int     brg_w;
        longint n;
        longint q;
        longint r;
        cnt_w = (d == 1) ? 8 : 16;
        brg_w = (d == 1) ? 8 : 16;
        os    = (d == 2) ? 2 : 4;
        n     = 64'(8 * p);
        if (n > (64'(1) << cnt_w)) return -1;
        q = n >> (3 + os);
        r = (q >= 1) ? q - 1 : 0;
        return int'(r % (64'(1) << brg_w));
    endfunction

    function automatic void push_exp(input int d, input int v);
        case (d)
            0:       q0.push_back(v);
            1:       q1.push_back(v);
            default: q2.push_back(v);
        endcase
    endfunction

    function automatic int q_size(input int d);
        case (d)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic bit pop_exp(input int d, output int v);
        v = -3;
        if (q_size(d) == 0) return 1'b0;
        case (d)
            0:       v = q0.pop_front();
            1:       v = q1.pop_front();
            default: v = q2.pop_front();
        endcase
        return 1'b1;
    endfunction

    // Monitor: every load pulse and every overflow rise consumes one expectation.
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (ld[d] === 1'b1) begin
                mon_got = pop_exp(d, mon_e);
                check("load_expected", d, int'(mon_got), 1);
                if (mon_got) begin
                    check("brg_value", d, brg_of(d), mon_e);
                    check("rxif_on_load", d, int'(rxif[d]), 1);
                    if (mon_e >= 0) last_brg[d] = mon_e;
                end
            end
            if (ovf[d] === 1'b1 && !ovf_prev[d]) begin
                mon_got = pop_exp(d, mon_e);
                check("ovf_expected", d, mon_got ? mon_e : -3, -1);
                check("brg_hold_on_ovf", d, brg_of(d), last_brg[d]);
            end
            ovf_prev[d] = (ovf[d] === 1'b1);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_all_zero(input string name);
        for (int d = 0; d < 3; d++) begin
            check({name, "_brg"}, d, brg_of(d), 0);
            check({name, "_load"}, d, int'(ld[d]), 0);
            check({name, "_rxif"}, d, int'(rxif[d]), 0);
            check({name, "_ovf"}, d, int'(ovf[d]), 0);
            check({name, "_busy"}, d, int'(busy[d]), 0);
        end
    endtask

    // Drives one framed 0x55; optional abort / reset / extra start at a bit index.
    task automatic send_frame(input int p, input int abort_bit, input int rst_bit, input bit extra_start);
        logic [9:0] bits;
        bits = {1'b1, 8'h55, 1'b0};
        rx = 1'b1;
        tick(4);
        for (int b = 0; b < 10; b++) begin
            rx = bits[b];
            if (b == abort_bit) begin
                abort = 1'b1;
                tick(1);
                abort = 1'b0;
                for (int d = 0; d < 3; d++) begin
                    check("busy_after_abort", d, int'(busy[d]), 0);
                    check("rxif_after_abort", d, int'(rxif[d]), 0);
                end
                tick(p - 1);
            end else if (b == rst_bit) begin
                cnt_rst = 1'b1;
                #1;
                check_all_zero("midreset");
                for (int d = 0; d < 3; d++) last_brg[d] = 0;
                tick(1);
                cnt_rst = 1'b0;
                tick(p - 1);
            end else if (extra_start && b == 2) begin
                abaud_start = 1'b1;
                tick(1);
                abaud_start = 1'b0;
                tick(p - 1);
            end else begin
                tick(p);
            end
        end
        rx = 1'b1;
        tick(10);
    endtask

    task automatic pulse_start();
        abaud_start = 1'b1;
        tick(1);
        abaud_start = 1'b0;
    endtask

    task automatic clear_and_check();
        irq_clr = 1'b1;
        tick(1);
        irq_clr = 1'b0;
        tick(1);
        for (int d = 0; d < 3; d++) begin
            check("rxif_cleared", d, int'(rxif[d]), 0);
            check("ovf_cleared", d, int'(ovf[d]), 0);
            check("brg_held", d, brg_of(d), last_brg[d]);
            check("busy_idle", d, int'(busy[d]), 0);
        end
    endtask

    // Full measurement: expectations are queued before the stimulus is issued.
    task automatic run_frame(input int p, input bit extra_start);
        int r [3];
        for (int d = 0; d < 3; d++) begin
            r[d] = model_result(d, p);
            push_exp(d, r[d]);
        end
        pulse_start();
        send_frame(p, -1, -1, extra_start);
        for (int d = 0; d < 3; d++) begin
            check("event_pending", d, q_size(d), 0);
            check("rxif_set", d, int'(rxif[d]), (r[d] >= 0) ? 1 : 0);
            check("ovf_set", d, int'(ovf[d]), (r[d] < 0) ? 1 : 0);
        end
        clear_and_check();
    endtask

    initial begin
        cnt_rst     = 1'b0;
        abaud_start = 1'b0;
        abort       = 1'b0;
        rx          = 1'b1;
        irq_clr     = 1'b0;
        for (int d = 0; d < 3; d++) begin
            last_brg[d] = 0;
            ovf_prev[d] = 1'b0;
        end
        #1 cnt_rst = 1'b1;
        #1;
        check_all_zero("reset");
        tick(3);
        cnt_rst = 1'b0;
        tick(2);

        // directed bit periods, including the 2^CNT_W boundary and Q = 0
        run_frame(32, 1'b1);
        run_frame(160, 1'b0);
        run_frame(40, 1'b0);
        run_frame(8, 1'b0);
        run_frame(2, 1'b0);

        // abort just after the 3rd falling edge, then a clean measurement
        pulse_start();
        send_frame(32, 4, -1, 1'b0);
        for (int d = 0; d < 3; d++) begin
            check("abort_no_event", d, q_size(d), 0);
            check("abort_rxif", d, int'(rxif[d]), 0);
            check("abort_brg_held", d, brg_of(d), last_brg[d]);
        end
        run_frame(32, 1'b0);

        // reset mid-measurement, then a sync byte with no new start request
        pulse_start();
        send_frame(32, -1, 5, 1'b0);
        send_frame(32, -1, -1, 1'b0);
        for (int d = 0; d < 3; d++) begin
            check("no_start_brg", d, brg_of(d), 0);
            check("no_start_busy", d, int'(busy[d]), 0);
            check("no_start_rxif", d, int'(rxif[d]), 0);
        end
        run_frame(160, 1'b0);

        // randomized bit periods
        for (int i = 0; i < 8; i++) begin
            run_frame(int'($urandom_range(2, 60)), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
